// File: rtl/fft_tone_pkg.sv
// Shared types and width helpers for the per-frame tone detector.
package fft_tone_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ATTACK,
    ACTIVE,
    RELEASE
  } state_t;

  function automatic int bin_w(input int n);
    return $clog2(n);
  endfunction

  // Running band sum can never overflow at this width.
  function automatic int sum_w(input int w, input int kmin, input int kmax);
    return w + $clog2(kmax - kmin + 2);
  endfunction

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fft_band_stats.sv
// Bin counter, in-band peak/sum tracking and frame-end latch.
module fft_band_stats
  import fft_tone_pkg::*;
#(
  parameter int W        = 33,
  parameter int NSamples = 256,
  parameter int K_MIN    = 20,
  parameter int K_MAX    = 100,
  localparam int BW      = bin_w(NSamples),
  localparam int SW      = sum_w(W, K_MIN, K_MAX)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  mag,
  input  logic          mag_valid,
  output logic          frame_done,
  output logic [W-1:0]  f_peak,
  output logic [BW-1:0] f_bin,
  output logic [SW-1:0] f_sum
);

  logic [BW-1:0] r_bin;
  logic [BW-1:0] r_pbin;
  logic [W-1:0]  r_peak;
  logic [SW-1:0] r_sum;

  logic          w_in_band;
  logic          w_gt;
  logic          w_last;
  logic [W-1:0]  w_peak_n;
  logic [BW-1:0] w_pbin_n;
  logic [SW-1:0] w_sum_n;

  assign w_in_band = (r_bin >= BW'(K_MIN)) && (r_bin <= BW'(K_MAX));
  // Strict compare: equal peaks keep the earlier (lower) bin.
  assign w_gt      = w_in_band && (mag > r_peak);
  assign w_peak_n  = w_gt ? mag : r_peak;
  assign w_pbin_n  = w_gt ? r_bin : r_pbin;
  assign w_sum_n   = w_in_band ? (r_sum + SW'(mag)) : r_sum;
  assign w_last    = (r_bin == BW'(NSamples - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bin      <= '0;
      r_pbin     <= '0;
      r_peak     <= '0;
      r_sum      <= '0;
      frame_done <= 1'b0;
      f_peak     <= '0;
      f_bin      <= '0;
      f_sum      <= '0;
    end else begin
      frame_done <= 1'b0;
      if (mag_valid) begin
        if (w_last) begin
          r_bin      <= '0;
          f_peak     <= w_peak_n;
          f_bin      <= w_pbin_n;
          f_sum      <= w_sum_n;
          frame_done <= 1'b1;
          r_peak     <= '0;
          r_pbin     <= '0;
          r_sum      <= '0;
        end else begin
          r_bin      <= r_bin + 1'b1;
          r_peak     <= w_peak_n;
          r_pbin     <= w_pbin_n;
          r_sum      <= w_sum_n;
        end
      end
    end
  end

endmodule

// File: rtl/fft_tone_detect.sv
// Per-frame dominant-tone test plus attack/release debounce.
// Define FFT_TONE_BIN_TRACK_EN to reject tone frames whose peak bin drifts.
module fft_tone_detect
  import fft_tone_pkg::*;
#(
  parameter int W          = 33,
  parameter int NSamples   = 256,
  parameter int K_MIN      = 20,
  parameter int K_MAX      = 100,
  parameter int MIN_PEAK   = 1024,
  parameter int RATIO_LOG2 = 2,
  parameter int ON_FRAMES  = 3,
  parameter int OFF_FRAMES = 5,
  parameter int BIN_TOL    = 2,
  localparam int BW        = bin_w(NSamples)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  mag,
  input  logic          mag_valid,
  output logic          frame_valid,
  output logic          tone_present,
  output logic [BW-1:0] tone_bin,
  output logic [W-1:0]  tone_peak,
  output logic          whistle_detected,
  output logic          whistle_onset
);

  localparam int SW   = sum_w(W, K_MIN, K_MAX);
  localparam int CW   = max2(W + RATIO_LOG2, SW);
  localparam int CNTW = $clog2(max2(ON_FRAMES, OFF_FRAMES) + 1);

  if (K_MIN > K_MAX || K_MAX >= NSamples / 2 || MIN_PEAK < 1 ||
      ON_FRAMES < 1 || OFF_FRAMES < 1 || BIN_TOL < 0) begin : g_cfg_err
    $error("fft_tone_detect: illegal parameter set");
  end

  logic          w_f_done;
  logic [W-1:0]  w_f_peak;
  logic [BW-1:0] w_f_bin;
  logic [SW-1:0] w_f_sum;
  logic [CW-1:0] w_pk_sh;
  logic [CW-1:0] w_sum_x;
  logic          w_tone;
  logic          w_t;

  state_t        r_state;
  logic [CNTW-1:0] r_cnt;

  fft_band_stats #(
    .W       (W),
    .NSamples(NSamples),
    .K_MIN   (K_MIN),
    .K_MAX   (K_MAX)
  ) u_stats (
    .clk       (clk),
    .reset     (reset),
    .mag       (mag),
    .mag_valid (mag_valid),
    .frame_done(w_f_done),
    .f_peak    (w_f_peak),
    .f_bin     (w_f_bin),
    .f_sum     (w_f_sum)
  );

  assign w_pk_sh = CW'(w_f_peak) << RATIO_LOG2;
  assign w_sum_x = CW'(w_f_sum);
  assign w_tone  = (w_f_peak >= W'(MIN_PEAK)) && (w_pk_sh >= w_sum_x);

`ifdef FFT_TONE_BIN_TRACK_EN
  logic [BW-1:0] r_ref;
  logic [BW-1:0] w_diff;
  logic          w_drift;

  assign w_diff  = (w_f_bin >= r_ref) ? (w_f_bin - r_ref) : (r_ref - w_f_bin);
  assign w_drift = (r_state != IDLE) && (w_diff > BW'(BIN_TOL));
  assign w_t     = w_tone && !w_drift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ref <= '0;
    end else if (w_f_done && w_tone) begin
      r_ref <= w_f_bin;
    end
  end
`else
  assign w_t = w_tone;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state          <= IDLE;
      r_cnt            <= '0;
      frame_valid      <= 1'b0;
      tone_present     <= 1'b0;
      tone_bin         <= '0;
      tone_peak        <= '0;
      whistle_detected <= 1'b0;
      whistle_onset    <= 1'b0;
    end else begin
      frame_valid   <= w_f_done;
      whistle_onset <= 1'b0;
      if (w_f_done) begin
        tone_present <= w_tone;
        tone_bin     <= w_f_bin;
        tone_peak    <= w_f_peak;
        unique case (r_state)
          IDLE: begin
            if (w_t) begin
              if (ON_FRAMES == 1) begin
                r_state          <= ACTIVE;
                whistle_detected <= 1'b1;
                whistle_onset    <= 1'b1;
              end else begin
                r_state <= ATTACK;
                r_cnt   <= CNTW'(1);
              end
            end
          end
          ATTACK: begin
            if (!w_t) begin
              r_state <= IDLE;
            end else if (r_cnt + 1'b1 == CNTW'(ON_FRAMES)) begin
              r_state          <= ACTIVE;
              whistle_detected <= 1'b1;
              whistle_onset    <= 1'b1;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          ACTIVE: begin
            if (!w_t) begin
              if (OFF_FRAMES == 1) begin
                r_state          <= IDLE;
                whistle_detected <= 1'b0;
              end else begin
                r_state <= RELEASE;
                r_cnt   <= CNTW'(1);
              end
            end
          end
          RELEASE: begin
            // Recovering from RELEASE is not a new onset.
            if (w_t) begin
              r_state <= ACTIVE;
            end else if (r_cnt + 1'b1 == CNTW'(OFF_FRAMES)) begin
              r_state          <= IDLE;
              whistle_detected <= 1'b0;
            end else begin
              r_cnt <= r_cnt + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_tone_detect.sv
// Randomized bench for fft_tone_detect against a frame-level reference model.
module tb_fft_tone_detect;

  localparam int W    = 33;
  localparam int NS   = 256;
  localparam int KMIN = 20;
  localparam int KMAX = 100;
  localparam int MINP = 1024;
  localparam int RL   = 2;
  localparam int ON   = 3;
  localparam int OFF  = 5;
  localparam int TOL  = 2;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] mag = '0;
  logic         mag_valid = 1'b0;
  logic         frame_valid;
  logic         tone_present;
  logic [7:0]   tone_bin;
  logic [W-1:0] tone_peak;
  logic         whistle_detected;
  logic         whistle_onset;

  fft_tone_detect dut (
    .clk             (clk),
    .reset           (reset),
    .mag             (mag),
    .mag_valid       (mag_valid),
    .frame_valid     (frame_valid),
    .tone_present    (tone_present),
    .tone_bin        (tone_bin),
    .tone_peak       (tone_peak),
    .whistle_detected(whistle_detected),
    .whistle_onset   (whistle_onset)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint cyc;
    bit     tp;
    int     bin;
    longint pk;
    bit     det;
    bit     ons;
  } exp_t;

  exp_t   q[$];
  exp_t   prev_e;
  exp_t   ce;
  int     errors = 0;
  int     checks = 0;
  longint cyc = 0;
  int     nfv = 0;
  int     n_onset = 0;
  int     onset_frame = 0;
  int     drop_frame = 0;
  bit     pdet = 1'b0;
  longint fr[NS];
  bit     m_det = 1'b0;
  int     m_on = 0;
  int     m_off = 0;
  int     m_ref = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Frame-level reference: band statistics, tone test, debounce run lengths.
  task automatic model_frame();
    longint s = 0;
    longint pk = 0;
    int     b = 0;
    bit     t;
    bit     te;
    exp_t   e;
    for (int k = KMIN; k <= KMAX; k++) begin
      s += fr[k];
      if (fr[k] > pk) pk = fr[k];
    end
    if (pk != 0)
      for (int k = KMAX; k >= KMIN; k--)
        if (fr[k] == pk) b = k;
    t  = (pk >= MINP) && ((pk << RL) >= s);
    te = t;
`ifdef FFT_TONE_BIN_TRACK_EN
    if (t && (m_det || m_on > 0) && (((b > m_ref) ? b - m_ref : m_ref - b) > TOL))
      te = 1'b0;
    if (t) m_ref = b;
`endif
    e.ons = 1'b0;
    if (!m_det) begin
      if (te) begin
        m_on++;
        if (m_on >= ON) begin
          m_det = 1'b1;
          e.ons = 1'b1;
          m_on  = 0;
          m_off = 0;
        end
      end else begin
        m_on = 0;
      end
    end else begin
      if (!te) begin
        m_off++;
        if (m_off >= OFF) begin
          m_det = 1'b0;
          m_off = 0;
          m_on  = 0;
        end
      end else begin
        m_off = 0;
      end
    end
    e.cyc = cyc + 2;
    e.tp  = t;
    e.bin = b;
    e.pk  = pk;
    e.det = m_det;
    q.push_back(e);
  endtask

  always begin
    @(negedge clk);
    #1;
    if (reset) begin
      chk("reset_outputs",
          {frame_valid, tone_present, whistle_detected, whistle_onset, tone_bin, tone_peak}, 0);
      prev_e = '{default: 0};
      pdet   = 1'b0;
    end else if (frame_valid) begin
      if (q.size() == 0) begin
        chk("unexpected_frame_valid", 1, 0);
      end else begin
        ce = q.pop_front();
        nfv++;
        chk("fv_cycle", cyc, ce.cyc);
        chk("tone_present", tone_present, ce.tp);
        chk("tone_bin", tone_bin, ce.bin);
        chk("tone_peak", tone_peak, ce.pk);
        chk("whistle_detected", whistle_detected, ce.det);
        chk("whistle_onset", whistle_onset, ce.ons);
        if (whistle_onset) begin
          n_onset++;
          onset_frame = nfv;
        end
        if (pdet && !whistle_detected) drop_frame = nfv;
        pdet   = whistle_detected;
        prev_e = ce;
      end
    end else begin
      chk("onset_outside_frame", whistle_onset, 0);
      chk("outputs_hold", {tone_present, whistle_detected, tone_bin, tone_peak},
          {prev_e.tp, prev_e.det, 8'(prev_e.bin), W'(prev_e.pk)});
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    mag_valid = 1'b0;
    m_det = 1'b0;
    m_on  = 0;
    m_off = 0;
    m_ref = 0;
    q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic drive_frame(input bit gaps, input int abort_at);
    for (int i = 0; i < NS; i++) begin
      if (i == abort_at) begin
        do_reset();
        return;
      end
      if (gaps)
        repeat ($urandom_range(0, 2)) begin
          @(negedge clk);
          mag_valid = 1'b0;
        end
      @(negedge clk);
      mag       = W'(fr[i]);
      mag_valid = 1'b1;
      if (i == NS - 1) model_frame();
    end
  endtask

  task automatic stop_bins();
    @(negedge clk);
    mag_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic fill(input longint v);
    for (int i = 0; i < NS; i++) fr[i] = v;
  endtask

  task automatic tone_frame(input int b);
    fill(10);
    fr[b] = 100000;
  endtask

  task automatic one_frame();
    drive_frame(1'b0, -1);
    stop_bins();
    drain();
  endtask

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    int base;
    int ons0;
    int pb;
    #2 reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    tone_frame(40);
    repeat (5) drive_frame(1'b0, -1);
    stop_bins();
    drain();
    chk("t1_onset_count", n_onset, 1);
    chk("t1_onset_frame", onset_frame, 3);
    chk("t1_bin", tone_bin, 40);
    chk("t1_peak", tone_peak, 100000);
    chk("t1_tone", tone_present, 1);
    chk("t1_det", whistle_detected, 1);

    base = nfv;
    fill(0);
    repeat (4) drive_frame(1'b0, -1);
    tone_frame(40);
    drive_frame(1'b0, -1);
    fill(0);
    repeat (5) drive_frame(1'b0, -1);
    stop_bins();
    drain();
    chk("t2_onset_count", n_onset, 1);
    chk("t2_drop_frame", drop_frame - base, 10);
    chk("t2_det", whistle_detected, 0);

    fill(0);
    for (int k = KMIN; k <= KMAX; k++) fr[k] = 5000;
    one_frame();
    chk("flat_tone", tone_present, 0);
    chk("flat_bin", tone_bin, 20);
    chk("flat_peak", tone_peak, 5000);

    fill(0);
    fr[10] = 1000000;
    one_frame();
    chk("outband_tone", tone_present, 0);
    chk("outband_peak", tone_peak, 0);

    fill(0);
    fr[30] = 1023;
    one_frame();
    chk("floor_below", tone_present, 0);
    fr[30] = 1024;
    fr[31] = 1024;
    fr[32] = 1024;
    fr[33] = 1024;
    one_frame();
    chk("ratio_equal", tone_present, 1);
    chk("ratio_equal_bin", tone_bin, 30);
    fr[34] = 1;
    one_frame();
    chk("ratio_over", tone_present, 0);

    fill(30);
    fr[90] = 900000;
    drive_frame(1'b1, 137);
    base = nfv;
    for (int i = 0; i < NS; i++) fr[i] = $urandom_range(0, 500);
    fr[55] = 200000;
    drive_frame(1'b1, -1);
    stop_bins();
    drain();
    chk("rst_frames", nfv - base, 1);
    chk("rst_bin", tone_bin, 55);
    chk("rst_peak", tone_peak, 200000);

    pb = 60;
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < NS; i++) fr[i] = $urandom_range(0, 1500);
      if ($urandom_range(0, 9) < 7) begin
        pb = pb + int'($urandom_range(0, 6)) - 3;
        if (pb < KMIN) pb = KMIN;
        if (pb > KMAX) pb = KMAX;
        fr[pb] = $urandom_range(10000, 2000000);
      end
      drive_frame(bit'($urandom_range(0, 1)), -1);
    end
    stop_bins();
    drain();

    do_reset();
    ons0 = n_onset;
    tone_frame(40);
    drive_frame(1'b0, -1);
    tone_frame(41);
    drive_frame(1'b0, -1);
    tone_frame(48);
    drive_frame(1'b0, -1);
    stop_bins();
    drain();
`ifdef FFT_TONE_BIN_TRACK_EN
    chk("track_onsets", n_onset - ons0, 0);
    chk("track_det", whistle_detected, 0);
`else
    chk("track_onsets", n_onset - ons0, 1);
    chk("track_det", whistle_detected, 1);
`endif
    chk("track_tone", tone_present, 1);
    chk("track_bin", tone_bin, 48);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
